// File: rtl/vga_pkg.sv
// Shared constants for the VGA test-pattern generator.
//   H_ACTIVE/V_ACTIVE : visible area of the 480p timing
//   FIELD             : side of the square play-field; pixels at or beyond it are border
//   BOX_SIZE          : side of the bouncing box
//   MODE_*            : pattern-select encodings
//   rgb_t colours     : 3-bit {R,G,B} on/off codes, expanded to full channel width at the output
package vga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned FIELD    = 480;
    localparam int unsigned BOX_SIZE = 16;

    localparam logic [2:0] MODE_SOLID     = 3'd0;
    localparam logic [2:0] MODE_GRID      = 3'd1;
    localparam logic [2:0] MODE_REF_LINES = 3'd2;
    localparam logic [2:0] MODE_CHECKER   = 3'd3;
    localparam logic [2:0] MODE_BARS      = 3'd4;
    localparam logic [2:0] MODE_BOUNCE    = 3'd5;

    typedef logic [2:0] rgb_t;

    localparam rgb_t BLACK = 3'b000;
    localparam rgb_t WHITE = 3'b111;
    localparam rgb_t RED   = 3'b100;
    localparam rgb_t GREEN = 3'b010;
    localparam rgb_t BLUE  = 3'b001;

endpackage

// File: rtl/vga_bounce_box.sv
// Bouncing-box position tracker. Steps one pixel per axis on every frame-end event and
// reverses direction at the play-field edges; each axis is independent.
//   clk_vga : pixel clock
//   rst     : synchronous active-high reset, box to (0,0) heading +x/+y
//   fe      : frame-end strobe
//   bx, by  : top-left corner of the box
module vga_bounce_box
    import vga_pkg::*;
#(
    parameter int unsigned COORD_W  = 10,
    parameter int unsigned FIELD    = vga_pkg::FIELD,
    parameter int unsigned BOX_SIZE = vga_pkg::BOX_SIZE
) (
    input  logic               clk_vga,
    input  logic               rst,
    input  logic               fe,
    output logic [COORD_W-1:0] bx,
    output logic [COORD_W-1:0] by
);

    localparam logic [COORD_W-1:0] POS_MAX = COORD_W'(FIELD - BOX_SIZE);
    localparam logic [COORD_W-1:0] ONE     = COORD_W'(1);

    logic [COORD_W-1:0] bx_q, bx_d, by_q, by_d;
    logic               x_neg_q, x_neg_d, y_neg_q, y_neg_d;

    // Returns {neg_next, pos_next}; a wall hit flips and steps away in the same frame.
    function automatic logic [COORD_W:0] step(input logic [COORD_W-1:0] pos, input logic neg);
        if (!neg && pos == POS_MAX) begin
            return {1'b1, pos - ONE};
        end else if (neg && pos == '0) begin
            return {1'b0, pos + ONE};
        end else begin
            return {neg, neg ? pos - ONE : pos + ONE};
        end
    endfunction

    always_comb begin
        {x_neg_d, bx_d} = step(bx_q, x_neg_q);
        {y_neg_d, by_d} = step(by_q, y_neg_q);
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            bx_q    <= '0;
            by_q    <= '0;
            x_neg_q <= 1'b0;
            y_neg_q <= 1'b0;
        end else if (fe) begin
            bx_q    <= bx_d;
            by_q    <= by_d;
            x_neg_q <= x_neg_d;
            y_neg_q <= y_neg_d;
        end
    end

    assign bx = bx_q;
    assign by = by_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// Runtime-selectable VGA test-pattern generator placed between the 480p timing driver and
// the pins. Colour and sync share one register stage, so they leave aligned.
//   clk_vga, rst            : pixel clock, synchronous active-high reset
//   sx, sy, de              : pixel position and data enable from the driver
//   hsync_in, vsync_in      : active-low syncs from the driver
//   mode, spacing, rgb_mask : pattern select (taken at frame end), grid/checker size, solid mask
//   vga_r/g/b               : registered colour
//   vga_hsync, vga_vsync    : syncs delayed to match colour
//   frame_cnt               : completed frames, wrapping
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int unsigned COLOR_W  = 4,
    parameter int unsigned COORD_W  = 10,
    parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int unsigned FIELD    = vga_pkg::FIELD,
    parameter int unsigned BOX_SIZE = vga_pkg::BOX_SIZE
) (
    input  logic               clk_vga,
    input  logic               rst,
    input  logic [COORD_W-1:0] sx,
    input  logic [COORD_W-1:0] sy,
    input  logic               de,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic [2:0]         mode,
    input  logic [3:0]         spacing,
    input  logic [2:0]         rgb_mask,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b,
    output logic               vga_hsync,
    output logic               vga_vsync,
    output logic [7:0]         frame_cnt
);

    localparam int unsigned        BAR_W    = H_ACTIVE / 8;
    localparam int unsigned        KW       = $clog2(COORD_W);
    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_ACTIVE - 1);
    localparam logic [COORD_W-1:0] F_SIDE   = COORD_W'(FIELD);
    localparam logic [COORD_W-1:0] F_HALF   = COORD_W'(FIELD / 2);
    localparam logic [COORD_W-1:0] F_LAST   = COORD_W'(FIELD - 1);
    localparam logic [COORD_W-1:0] BAR_LAST = COORD_W'(BAR_W - 1);

    logic [2:0]         mode_q;
    logic [3:0]         px_q, py_q, px_cur, py_cur;
    logic [COORD_W-1:0] bar_cnt_q, bar_cur;
    logic [2:0]         idx_q, idx_cur;
    logic [COORD_W-1:0] bx, by;
    logic [KW-1:0]      chk_k;
    logic               fe, line_end, in_field, in_box;
    rgb_t               code;

    assign line_end = de && (sx == X_LAST);
    assign fe       = line_end && (sy == Y_LAST);
    assign in_field = (sx < F_SIDE) && (sy < F_SIDE);

    vga_bounce_box #(
        .COORD_W  (COORD_W),
        .FIELD    (FIELD),
        .BOX_SIZE (BOX_SIZE)
    ) u_box (
        .clk_vga (clk_vga),
        .rst     (rst),
        .fe      (fe),
        .bx      (bx),
        .by      (by)
    );

    // Phase counters restart at the left edge / top line, so their registered value is
    // overridden there instead of relying on a reset pulse per line.
    always_comb begin
        px_cur  = (sx == '0) ? 4'd0 : px_q;
        py_cur  = (sy == '0) ? 4'd0 : py_q;
        bar_cur = (sx == '0) ? '0 : bar_cnt_q;
        idx_cur = (sx == '0) ? 3'd0 : idx_q;
        chk_k   = (32'(spacing) > COORD_W - 1) ? KW'(COORD_W - 1) : KW'(spacing);
        in_box  = ({1'b0, sx} >= {1'b0, bx}) &&
                  ({1'b0, sx} <  {1'b0, bx} + (COORD_W + 1)'(BOX_SIZE)) &&
                  ({1'b0, sy} >= {1'b0, by}) &&
                  ({1'b0, sy} <  {1'b0, by} + (COORD_W + 1)'(BOX_SIZE));
    end

    always_comb begin
        code = BLACK;
        case (mode_q)
            MODE_SOLID: code = rgb_mask;
            MODE_GRID: begin
                if (in_field && (px_cur == spacing || py_cur == spacing)) code = WHITE;
            end
            MODE_REF_LINES: begin
                if (sx == sy)                          code = BLACK;
                else if (sx == '0 || sy == '0)         code = BLUE;
                else if (sx == F_HALF || sy == F_HALF) code = RED;
                else if (sx == F_LAST || sy == F_LAST) code = GREEN;
                else                                   code = WHITE;
            end
            MODE_CHECKER: code = (sx[chk_k] ^ sy[chk_k]) ? WHITE : BLACK;
            MODE_BARS:    code = idx_cur;
            MODE_BOUNCE:  code = (in_field && in_box) ? WHITE : BLACK;
            default:      code = BLACK;
        endcase
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            mode_q    <= mode;
            px_q      <= 4'd0;
            py_q      <= 4'd0;
            bar_cnt_q <= '0;
            idx_q     <= 3'd0;
            frame_cnt <= 8'd0;
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
        end else begin
            if (de) begin
                // >= rather than == keeps the counter bounded if spacing shrinks mid-line.
                px_q <= (px_cur >= spacing) ? 4'd0 : px_cur + 4'd1;
                if (bar_cur == BAR_LAST) begin
                    bar_cnt_q <= '0;
                    idx_q     <= idx_cur + 3'd1;
                end else begin
                    bar_cnt_q <= bar_cur + COORD_W'(1);
                    idx_q     <= idx_cur;
                end
            end
            if (line_end) py_q <= (py_cur >= spacing) ? 4'd0 : py_cur + 4'd1;
            if (fe) begin
                mode_q    <= mode;
                frame_cnt <= frame_cnt + 8'd1;
            end
            vga_r     <= de ? {COLOR_W{code[2]}} : '0;
            vga_g     <= de ? {COLOR_W{code[1]}} : '0;
            vga_b     <= de ? {COLOR_W{code[0]}} : '0;
            vga_hsync <= hsync_in;
            vga_vsync <= vsync_in;
        end
    end

endmodule
